double_buffer_main: RTL and testbench
=====================================

# double_buffer_main

Double-buffered frame store and pattern renderer for the VGA example. A raster renderer writes one pixel per clock into the back buffer. When a frame is complete, the buffers swap, so the front buffer shown on `packed_buffer` always holds a complete, tear-free frame. Downstream VGA scan-out logic and simulation benches read the front buffer as one flat bus.

## Interface
- `WIDTH`, default 640: pixels per row.
- `HEIGHT`, default 480: rows per frame.
- `PIXEL_SIZE`, default 8: bits per pixel.
- `clk`, input, 1 bit: the single clock, rising-edge.
- `resetn`, input, 1 bit: reset.
  - One clock; reset is asynchronous and active-high. The port keeps the codebase name `resetn`, but it is asserted at 1.
- `packed_buffer`, output, `WIDTH*HEIGHT*PIXEL_SIZE` bits (2457600 at defaults): the front frame.
  - Pixel at row y, column x occupies bits `[(y*WIDTH + x)*PIXEL_SIZE +: PIXEL_SIZE]`.
  - Row-major order; pixel LSB sits at the lower bit index.

## Operation
- State:
  - two frame stores A and B, each `WIDTH*HEIGHT*PIXEL_SIZE` bits;
  - `front_sel` (0 = A is front, 1 = B is front);
  - column counter `x` (0..WIDTH-1) and row counter `y` (0..HEIGHT-1);
  - 8-bit frame counter `frame`.
- Reset (asynchronous, `resetn`=1):
  - both stores cleared to 0;
  - `front_sel`=0, `x`=0, `y`=0, `frame`=0.
  - `packed_buffer` therefore reads all zeros during and immediately after reset.
- Each clock while out of reset:
  - Writes pixel (x,y) of the back store (the store not selected by `front_sel`).
  - Written value is `(x + y + frame) mod 2^PIXEL_SIZE`, computed in at least 32-bit width and then truncated.
- Counter advance:
  - `x` increments each clock.
  - At `x`=WIDTH-1: `x` wraps to 0 and `y` increments.
  - At `x`=WIDTH-1 and `y`=HEIGHT-1 (last pixel), on that same edge:
    - the last pixel is written;
    - `x` and `y` wrap to 0;
    - `front_sel` toggles;
    - `frame` increments modulo 256.
- `packed_buffer` is a pure mux of the front store by `front_sel`. There are no other combinational paths.
- The front store is never written while it is front. No partial frame is ever visible.
- Reset asserted mid-frame: the partially rendered back frame is discarded (cleared). Rendering restarts at (0,0) with `frame`=0.
- Continuous operation: there is no stall or enable input. The renderer runs free.

## Timing
- Pixel write latency: 1 clock. The value for (x,y) lands on the edge where the counters equal (x,y).
- Frame period: `WIDTH*HEIGHT` clocks (307200 at defaults).
- First non-zero frame:
  - `packed_buffer` changes on the `WIDTH*HEIGHT`-th rising edge after reset deassertion.
  - It then shows frame 0: pixel = x+y truncated.
- Frame n (n≥0) becomes visible on edge `(n+1)*WIDTH*HEIGHT`.
  - It holds until the next swap edge.
  - Pixel value is `(x+y+n) mod 256`.
- Swap and last-pixel write occur on the same edge. The last pixel is already in the store that becomes front.

## Structure
- Shared package `vga_defs`: `WIDTH`, `HEIGHT`, `PIXEL_SIZE`, and derived `FRAME_BITS = WIDTH*HEIGHT*PIXEL_SIZE`. Scan-out logic uses the same constants.
- Sub-module `frame_store`, instantiated twice (A and B):
  - one write port (x, y, data, write-enable);
  - asynchronous clear;
  - flat read-out bus.
- Top level holds the counters, the pattern adder, `front_sel` and the output mux.

## Test plan
- Reset hold:
  - Stimulus: assert `resetn`=1 for 10 clocks.
  - Response: `packed_buffer` is all zeros; it stays zero through edge `WIDTH*HEIGHT-1` after release.
- First swap (parameters WIDTH=4, HEIGHT=2):
  - Stimulus: release reset and run 8 clocks.
  - Response: after edge 8, row 0 = 0,1,2,3 and row 1 = 1,2,3,4. Before edge 8, output is all zeros.
- Second frame (WIDTH=4, HEIGHT=2):
  - Response: after edge 16, row 0 = 1,2,3,4 and row 1 = 2,3,4,5.
  - Between edges 9 and 15, output is unchanged from frame 0 (no tearing).
- Wrap (WIDTH=4, HEIGHT=2):
  - Stimulus: run 256 frames.
  - Response: frame 256 pixel (0,0) = 0 and pixel (3,1) = 4.
  - At defaults: frame 0 pixel (639,479) = (1118 mod 256) = 94.
- Mid-frame reset (WIDTH=4, HEIGHT=2):
  - Stimulus: reset asserted asynchronously at clock 12, then released.
  - Response: output is immediately zero; frame 0 pattern reappears exactly 8 edges after release.
- Bit packing (defaults):
  - Check: `packed_buffer[(1*640+2)*8 +: 8]` = 3 after the first swap.

Source files
------------

// File: rtl/double_buffer_main_pkg.sv
// Shared VGA frame geometry used by the renderer, the frame stores and scan-out.
package vga_defs;

  localparam int unsigned WIDTH      = 640;
  localparam int unsigned HEIGHT     = 480;
  localparam int unsigned PIXEL_SIZE = 8;
  localparam int unsigned FRAME_BITS = WIDTH * HEIGHT * PIXEL_SIZE;

  // Counter/index width that stays at least one bit for degenerate sizes.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/double_buffer_main_frame_store.sv
// One full frame of pixels: single write port, async clear, flat read-out.
module frame_store #(
  parameter int unsigned WIDTH      = vga_defs::WIDTH,
  parameter int unsigned HEIGHT     = vga_defs::HEIGHT,
  parameter int unsigned PIXEL_SIZE = vga_defs::PIXEL_SIZE,
  parameter int unsigned XW         = vga_defs::cnt_width(WIDTH),
  parameter int unsigned YW         = vga_defs::cnt_width(HEIGHT)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 we_i,
  input  logic [XW-1:0]                        x_i,
  input  logic [YW-1:0]                        y_i,
  input  logic [PIXEL_SIZE-1:0]                data_i,
  output logic [WIDTH*HEIGHT*PIXEL_SIZE-1:0]   frame_o
);

  localparam int unsigned FB = WIDTH * HEIGHT * PIXEL_SIZE;
  localparam int unsigned AW = vga_defs::cnt_width(FB);

  logic [FB-1:0] mem_q;
  logic [AW-1:0] base_c;

  // Row-major bit offset of pixel (x,y).
  always_comb begin
    base_c = AW'((32'(y_i) * WIDTH + 32'(x_i)) * PIXEL_SIZE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
    end else if (we_i) begin
      mem_q[base_c +: PIXEL_SIZE] <= data_i;
    end
  end

  assign frame_o = mem_q;

endmodule

// File: rtl/double_buffer_main.sv
// Double-buffered frame store with a free-running raster pattern renderer;
// the front store is shown on packed_buffer and swapped after each full frame.
module double_buffer_main #(
  parameter int unsigned WIDTH      = vga_defs::WIDTH,
  parameter int unsigned HEIGHT     = vga_defs::HEIGHT,
  parameter int unsigned PIXEL_SIZE = vga_defs::PIXEL_SIZE
) (
  input  logic                               clk,
  input  logic                               resetn,
  output logic [WIDTH*HEIGHT*PIXEL_SIZE-1:0] packed_buffer
);

  localparam int unsigned FB = WIDTH * HEIGHT * PIXEL_SIZE;
  localparam int unsigned XW = vga_defs::cnt_width(WIDTH);
  localparam int unsigned YW = vga_defs::cnt_width(HEIGHT);

  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [7:0]            frame_q, frame_d;
  logic                  front_sel_q, front_sel_d;
  logic                  last_x_c, last_y_c;
  logic [PIXEL_SIZE-1:0] pix_c;
  logic [FB-1:0]         store_a, store_b;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      x_q         <= '0;
      y_q         <= '0;
      frame_q     <= '0;
      front_sel_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      frame_q     <= frame_d;
      front_sel_q <= front_sel_d;
    end
  end

  // Raster advance; the swap shares its edge with the last-pixel write.
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    frame_d     = frame_q;
    front_sel_d = front_sel_q;
    last_x_c    = (x_q == XW'(WIDTH - 1));
    last_y_c    = (y_q == YW'(HEIGHT - 1));
    if (last_x_c) begin
      x_d = '0;
      if (last_y_c) begin
        y_d         = '0;
        front_sel_d = ~front_sel_q;
        frame_d     = frame_q + 8'd1;
      end else begin
        y_d = y_q + YW'(1);
      end
    end else begin
      x_d = x_q + XW'(1);
    end
  end

  always_comb begin
    pix_c = PIXEL_SIZE'(32'(x_q) + 32'(y_q) + 32'(frame_q));
  end

  // Only the back store (not selected by front_sel) is ever written.
  frame_store #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .PIXEL_SIZE(PIXEL_SIZE), .XW(XW), .YW(YW)
  ) u_store_a (
    .clk     (clk),
    .rst     (resetn),
    .we_i    (front_sel_q),
    .x_i     (x_q),
    .y_i     (y_q),
    .data_i  (pix_c),
    .frame_o (store_a)
  );

  frame_store #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .PIXEL_SIZE(PIXEL_SIZE), .XW(XW), .YW(YW)
  ) u_store_b (
    .clk     (clk),
    .rst     (resetn),
    .we_i    (~front_sel_q),
    .x_i     (x_q),
    .y_i     (y_q),
    .data_i  (pix_c),
    .frame_o (store_b)
  );

  assign packed_buffer = front_sel_q ? store_b : store_a;

endmodule

// File: tb/tb_double_buffer_main.sv
// Directed bench: small 4x2 instance for frame timing, 640x2 instance for bit packing.
module tb_double_buffer_main;

  localparam int unsigned SW = 4;
  localparam int unsigned SH = 2;
  localparam int unsigned SB = SW * SH * 8;
  localparam int unsigned BW = 640;
  localparam int unsigned BH = 2;
  localparam int unsigned BB = BW * BH * 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SB-1:0] sb;
  logic [BB-1:0] bb;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  typedef struct {
    int at;    // edge count after reset release
    int frm;   // frame expected on the output, -1 for all zeros
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  double_buffer_main #(.WIDTH(SW), .HEIGHT(SH), .PIXEL_SIZE(8)) u_small (
    .clk           (clk),
    .resetn        (rst),
    .packed_buffer (sb)
  );

  double_buffer_main #(.WIDTH(BW), .HEIGHT(BH), .PIXEL_SIZE(8)) u_big (
    .clk           (clk),
    .resetn        (rst),
    .packed_buffer (bb)
  );

  function automatic logic [SB-1:0] model(input int n);
    logic [SB-1:0] v;
    v = '0;
    if (n >= 0) begin
      for (int y = 0; y < int'(SH); y++) begin
        for (int x = 0; x < int'(SW); x++) begin
          v[(y * SW + x) * 8 +: 8] = 8'(x + y + n);
        end
      end
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Called at a negedge; steps posedges until edge_n reaches target, returns at a negedge.
  task automatic advance_to(input int target);
    while (edge_n < target) begin
      @(posedge clk);
      edge_n++;
      @(negedge clk);
    end
  endtask

  task automatic release_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    vecs[0] = '{0, -1};
    vecs[1] = '{1, -1};
    vecs[2] = '{7, -1};
    vecs[3] = '{8, 0};
    vecs[4] = '{9, 0};
    vecs[5] = '{15, 0};
    vecs[6] = '{16, 1};
    vecs[7] = '{23, 1};
    vecs[8] = '{24, 2};

    // Reset hold for 10 clocks
    repeat (10) @(negedge clk);
    check("reset_hold_small", 64'(sb), 64'(0));
    check("reset_hold_big_nonzero", 64'(bb != '0), 64'(0));
    rst = 1'b0;
    edge_n = 0;

    foreach (vecs[i]) begin
      advance_to(vecs[i].at);
      check($sformatf("frame_at_edge_%0d", vecs[i].at), 64'(sb), 64'(model(vecs[i].frm)));
    end

    // Wide instance: zero until its first swap, then frame 0 bit packing
    advance_to(int'(BW * BH) - 1);
    check("big_pre_swap_nonzero", 64'(bb != '0), 64'(0));
    advance_to(int'(BW * BH));
    check("big_pix_2_1", 64'(bb[(1 * BW + 2) * 8 +: 8]), 64'(3));
    check("big_pix_639_1", 64'(bb[(1 * BW + 639) * 8 +: 8]), 64'(128));
    check("big_pix_1_0", 64'(bb[1 * 8 +: 8]), 64'(1));
    check("small_frame_159", 64'(sb), 64'(model(159)));

    // Frame counter wrap
    advance_to(256 * 8);
    check("small_frame_255", 64'(sb), 64'(model(255)));
    check("pix00_frame_255", 64'(sb[7:0]), 64'(255));
    advance_to(257 * 8);
    check("small_frame_256", 64'(sb), 64'(model(0)));
    check("pix00_frame_256", 64'(sb[7:0]), 64'(0));
    check("pix31_frame_256", 64'(sb[(1 * SW + 3) * 8 +: 8]), 64'(4));

    // Mid-frame asynchronous reset at clock 12
    release_reset();
    advance_to(12);
    check("pre_async_reset", 64'(sb), 64'(model(0)));
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset_immediate", 64'(sb), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    edge_n = 0;
    advance_to(7);
    check("post_reset_edge7", 64'(sb), 64'(0));
    advance_to(8);
    check("post_reset_edge8", 64'(sb), 64'(model(0)));
    advance_to(16);
    check("post_reset_edge16", 64'(sb), 64'(model(1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
